// File: rtl/logic_unit_pipe.sv
// Pipelined 8-function bitwise logic unit with valid/ready backpressure.
// Zero and parity flags are computed at capture and ride along with each result.
module logic_unit_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALU_FUN,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Logic_OUT,
  output logic             Logic_Flag,
  output logic             Zero_Flag,
  output logic             Parity_Flag
);

  localparam int LAST = STAGES - 1;

  logic [WIDTH-1:0] result_next;
  logic             zero_next;
  logic             parity_next;

  always_comb begin
    result_next = '0;
    case (ALU_FUN)
      3'b000:  result_next = A & B;
      3'b001:  result_next = A | B;
      3'b010:  result_next = ~(A & B);
      3'b011:  result_next = ~(A | B);
      3'b100:  result_next = A ^ B;
      3'b101:  result_next = ~(A ^ B);
      3'b110:  result_next = ~A;
      default: result_next = A & ~B;
    endcase
  end

  assign zero_next   = ~|result_next;
  assign parity_next = ^result_next;

  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] stage_zero;
  logic [STAGES-1:0] stage_parity;
  logic [WIDTH-1:0]  stage_data [STAGES];
  logic [STAGES-1:0] adv;

  // A stage may load when it is empty or its own content moves on this cycle,
  // so a stalled output lets earlier stages close bubbles without overwriting.
  always_comb begin
    adv       = '0;
    adv[LAST] = Out_Ready | ~stage_valid[LAST];
    for (int k = LAST - 1; k >= 0; k--) begin
      adv[k] = adv[k+1] | ~stage_valid[k];
    end
  end

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      logic             valid_reg;
      logic             zero_reg;
      logic             parity_reg;
      logic [WIDTH-1:0] data_reg;
      logic             src_valid;
      logic             src_zero;
      logic             src_parity;
      logic [WIDTH-1:0] src_data;

      if (gi == 0) begin : g_head
        assign src_valid  = In_Valid;
        assign src_data   = result_next;
        assign src_zero   = zero_next;
        assign src_parity = parity_next;
      end else begin : g_body
        assign src_valid  = stage_valid[gi-1];
        assign src_data   = stage_data[gi-1];
        assign src_zero   = stage_zero[gi-1];
        assign src_parity = stage_parity[gi-1];
      end

      // Payload only updates on a valid load; an empty stage keeps stale data
      // that the output gating hides.
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          valid_reg  <= 1'b0;
          data_reg   <= '0;
          zero_reg   <= 1'b0;
          parity_reg <= 1'b0;
        end else if (adv[gi]) begin
          valid_reg <= src_valid;
          if (src_valid) begin
            data_reg   <= src_data;
            zero_reg   <= src_zero;
            parity_reg <= src_parity;
          end
        end
      end

      assign stage_valid[gi]  = valid_reg;
      assign stage_data[gi]   = data_reg;
      assign stage_zero[gi]   = zero_reg;
      assign stage_parity[gi] = parity_reg;
    end
  endgenerate

  assign In_Ready    = adv[0];
  assign Logic_Flag  = stage_valid[LAST];
  assign Logic_OUT   = stage_data[LAST] & {WIDTH{stage_valid[LAST]}};
  assign Zero_Flag   = stage_zero[LAST] & stage_valid[LAST];
  assign Parity_Flag = stage_parity[LAST] & stage_valid[LAST];

endmodule
